// File: rtl/vid_pkg.sv
// Shared definitions for the video frame source.
// Holds the default raster timing, the packed RGB pixel type, the
// controller state encoding, and a counter-width helper.
package vid_pkg;

    localparam int DEF_DATA_WIDTH = 24;
    localparam int DEF_HRES       = 320;
    localparam int DEF_VRES       = 240;
    localparam int DEF_HFP        = 8;
    localparam int DEF_HSW        = 16;
    localparam int DEF_HBP        = 8;
    localparam int DEF_VFP        = 2;
    localparam int DEF_VSW        = 2;
    localparam int DEF_VBP        = 2;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/video_frame_source_if.sv
// Bus bundle between the frame source, its frame memory and the video sink.
//   i_en          run request into the source
//   o_rd_en       frame-memory read strobe
//   o_rd_addr     frame-memory pixel address
//   i_rd_data     read data, one clock after o_rd_en
//   o_vsync/o_hsync/o_de  active-high timing
//   o_data        pixel data, zero outside o_de
//   o_frame_done  one-clock end-of-frame pulse
// master = the frame source, slave = memory/sink side.
interface video_frame_source_if #(
    parameter int DATA_WIDTH = vid_pkg::DEF_DATA_WIDTH,
    parameter int AW         = vid_pkg::cnt_w(vid_pkg::DEF_HRES * vid_pkg::DEF_VRES)
);
    logic                  i_en;
    logic                  o_rd_en;
    logic [AW-1:0]         o_rd_addr;
    logic [DATA_WIDTH-1:0] i_rd_data;
    logic                  o_vsync;
    logic                  o_hsync;
    logic                  o_de;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_frame_done;

    modport master (
        input  i_en,
        input  i_rd_data,
        output o_rd_en,
        output o_rd_addr,
        output o_vsync,
        output o_hsync,
        output o_de,
        output o_data,
        output o_frame_done
    );

    modport slave (
        output i_en,
        output i_rd_data,
        input  o_rd_en,
        input  o_rd_addr,
        input  o_vsync,
        input  o_hsync,
        input  o_de,
        input  o_data,
        input  o_frame_done
    );
endinterface

// File: rtl/video_timing_counter.sv
// Raster position counters for the frame source.
// Ports:
//   clk, rst   clock and async active-high reset
//   i_run      count while high; held at 0,0 while low
//   o_hcnt     pixel position in line, 0..HTOTAL-1
//   o_vcnt     line position in frame, 0..VTOTAL-1
//   o_active   position is inside the active picture
//   o_hsync    position is inside the horizontal sync pulse
//   o_vsync    position is on a vertical sync line
//   o_last     final position of the frame
// Each line/frame is ordered active, front porch, sync, back porch.
module video_timing_counter
    import vid_pkg::*;
#(
    parameter int HRES = DEF_HRES,
    parameter int VRES = DEF_VRES,
    parameter int HFP  = DEF_HFP,
    parameter int HSW  = DEF_HSW,
    parameter int HBP  = DEF_HBP,
    parameter int VFP  = DEF_VFP,
    parameter int VSW  = DEF_VSW,
    parameter int VBP  = DEF_VBP,
    localparam int HTOTAL = HRES + HFP + HSW + HBP,
    localparam int VTOTAL = VRES + VFP + VSW + VBP,
    localparam int HCW    = cnt_w(HTOTAL),
    localparam int VCW    = cnt_w(VTOTAL)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_run,
    output logic [HCW-1:0] o_hcnt,
    output logic [VCW-1:0] o_vcnt,
    output logic           o_active,
    output logic           o_hsync,
    output logic           o_vsync,
    output logic           o_last
);
    localparam logic [HCW-1:0] H_ACT  = HCW'(HRES);
    localparam logic [HCW-1:0] HS_BEG = HCW'(HRES + HFP);
    localparam logic [HCW-1:0] HS_END = HCW'(HRES + HFP + HSW);
    localparam logic [HCW-1:0] H_LAST = HCW'(HTOTAL - 1);
    localparam logic [VCW-1:0] V_ACT  = VCW'(VRES);
    localparam logic [VCW-1:0] VS_BEG = VCW'(VRES + VFP);
    localparam logic [VCW-1:0] VS_END = VCW'(VRES + VFP + VSW);
    localparam logic [VCW-1:0] V_LAST = VCW'(VTOTAL - 1);

    logic [HCW-1:0] hcnt_d, hcnt_q;
    logic [VCW-1:0] vcnt_d, vcnt_q;

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (!i_run) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end else if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        end else begin
            hcnt_d = hcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign o_hcnt   = hcnt_q;
    assign o_vcnt   = vcnt_q;
    assign o_active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    assign o_hsync  = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
    assign o_vsync  = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
    assign o_last   = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);

endmodule

// File: rtl/video_frame_source.sv
// Frame source: walks a raster, reads each active pixel from a frame
// memory and presents it with hsync/vsync/de timing.
// Ports:
//   clk, rst   clock and async active-high reset
//   bus        video_frame_source_if.master (run request, memory read
//              port, timing and pixel outputs)
// Read strobe and address follow the counter state directly; memory data
// returns one clock later, so timing outputs are registered once to line
// up with it.
module video_frame_source
    import vid_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int HRES       = DEF_HRES,
    parameter int VRES       = DEF_VRES,
    parameter int HFP        = DEF_HFP,
    parameter int HSW        = DEF_HSW,
    parameter int HBP        = DEF_HBP,
    parameter int VFP        = DEF_VFP,
    parameter int VSW        = DEF_VSW,
    parameter int VBP        = DEF_VBP
) (
    input  logic                 clk,
    input  logic                 rst,
    video_frame_source_if.master bus
);
    localparam int HTOTAL = HRES + HFP + HSW + HBP;
    localparam int VTOTAL = VRES + VFP + VSW + VBP;
    localparam int HCW    = cnt_w(HTOTAL);
    localparam int VCW    = cnt_w(VTOTAL);
    localparam int NPIX   = HRES * VRES;
    localparam int AW     = cnt_w(NPIX);
    localparam logic [HCW-1:0] H_LAST    = HCW'(HTOTAL - 1);
    localparam logic [VCW-1:0] V_LAST    = VCW'(VTOTAL - 1);
    localparam logic [AW-1:0]  ADDR_LAST = AW'(NPIX - 1);

    state_t         state_d, state_q;
    logic [AW-1:0]  addr_d, addr_q;
    logic           de_d, de_q;
    logic           hsync_d, hsync_q;
    logic           vsync_d, vsync_q;
    logic           done_d, done_q;

    logic           run;
    logic           rd_en;
    logic [HCW-1:0] hcnt;
    logic [VCW-1:0] vcnt;
    logic           cnt_active;
    logic           cnt_hsync;
    logic           cnt_vsync;
    logic           cnt_last;

    assign run = (state_q == ST_RUN);

    video_timing_counter #(
        .HRES (HRES),
        .VRES (VRES),
        .HFP  (HFP),
        .HSW  (HSW),
        .HBP  (HBP),
        .VFP  (VFP),
        .VSW  (VSW),
        .VBP  (VBP)
    ) u_timing (
        .clk      (clk),
        .rst      (rst),
        .i_run    (run),
        .o_hcnt   (hcnt),
        .o_vcnt   (vcnt),
        .o_active (cnt_active),
        .o_hsync  (cnt_hsync),
        .o_vsync  (cnt_vsync),
        .o_last   (cnt_last)
    );

    assign rd_en = run && cnt_active;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;

        // i_en is only looked at on the frame's final position, so a
        // dropped request always lets the current frame finish.
        unique case (state_q)
            ST_IDLE: if (bus.i_en) state_d = ST_RUN;
            ST_RUN:  if (cnt_last && !bus.i_en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // The end-of-frame clear keeps the next frame starting at 0 even
        // if the wrap compare were ever bypassed.
        if (!run || ((hcnt == H_LAST) && (vcnt == V_LAST))) begin
            addr_d = '0;
        end else if (rd_en) begin
            addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
        end

        de_d    = rd_en;
        hsync_d = run && cnt_hsync;
        vsync_d = run && cnt_vsync;
        done_d  = run && cnt_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            de_q    <= 1'b0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_rd_en      = rd_en;
    assign bus.o_rd_addr    = addr_q;
    assign bus.o_de         = de_q;
    assign bus.o_hsync      = hsync_q;
    assign bus.o_vsync      = vsync_q;
    assign bus.o_frame_done = done_q;
    assign bus.o_data       = de_q ? bus.i_rd_data : '0;

endmodule
